seq_mag_comparator: RTL and testbench

Parametrised, digit-serial magnitude comparator with a start/done handshake. It takes two WIDTH-bit operands and compares them MSB-first, DIGIT bits per clock, producing mutually exclusive greater/equal/less flags. It generalises the team's fixed 6-bit hierarchical comparator in three ways: any width, optional two's-complement ordering, and optional early termination. It sits as a shared compare resource behind a simple request/response handshake.

---
 rtl/seq_mag_comparator.sv | 131 +++++++++++++
 tb/tb_seq_mag_comparator.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_mag_comparator.sv
// seq_mag_comparator: digit-serial MSB-first magnitude comparator with a
// start/done handshake. Operands are compared DIGIT bits per clock; the
// result is presented as mutually exclusive gt/eq/lt flags.
//
// Build option: define EARLY_EXIT_EN to finish on the first differing digit
// (data-dependent latency 1..N). Without it, every run lasts exactly N cycles.
module seq_mag_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
  localparam logic [CW-1:0]    LAST_CNT = CW'(N - 1);

  logic [0:0]       state_reg;
  logic [WIDTH-1:0] sa_reg;
  logic [WIDTH-1:0] sb_reg;
  logic [CW-1:0]    cnt_reg;
  logic             decided_reg;
  logic             dir_gt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             gt_reg;
  logic             eq_reg;
  logic             lt_reg;

  logic [DIGIT-1:0] digit_a;
  logic [DIGIT-1:0] digit_b;
  logic             digit_diff;
  logic             digit_gt;
  logic             last_digit;
  logic             finish;
  logic             any_diff;
  logic             res_gt;

  // Current-digit comparison and completion decision.
  always_comb begin
    digit_a    = sa_reg[WIDTH-1 -: DIGIT];
    digit_b    = sb_reg[WIDTH-1 -: DIGIT];
    digit_diff = (digit_a != digit_b);
    digit_gt   = (digit_a > digit_b);
    last_digit = (cnt_reg == LAST_CNT);
    // An earlier latched difference always wins over the current digit.
    any_diff   = decided_reg | digit_diff;
    res_gt     = decided_reg ? dir_gt_reg : digit_gt;
`ifdef EARLY_EXIT_EN
    finish     = last_digit | (digit_diff & ~decided_reg);
`else
    finish     = last_digit;
`endif
  end

  // Handshake FSM, operand shifting and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      sa_reg      <= '0;
      sb_reg      <= '0;
      cnt_reg     <= '0;
      decided_reg <= 1'b0;
      dir_gt_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      gt_reg      <= 1'b0;
      eq_reg      <= 1'b0;
      lt_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            sa_reg      <= signed_mode ? (a ^ MSB_MASK) : a;
            sb_reg      <= signed_mode ? (b ^ MSB_MASK) : b;
            cnt_reg     <= '0;
            decided_reg <= 1'b0;
            dir_gt_reg  <= 1'b0;
            gt_reg      <= 1'b0;
            eq_reg      <= 1'b0;
            lt_reg      <= 1'b0;
            busy_reg    <= 1'b1;
            state_reg   <= S_RUN;
          end
        end
        default: begin
          if (digit_diff && !decided_reg) begin
            decided_reg <= 1'b1;
            dir_gt_reg  <= digit_gt;
          end
          if (finish) begin
            gt_reg    <= any_diff & res_gt;
            lt_reg    <= any_diff & ~res_gt;
            eq_reg    <= ~any_diff;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            sa_reg  <= sa_reg << DIGIT;
            sb_reg  <= sb_reg << DIGIT;
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign gt   = gt_reg;
  assign eq   = eq_reg;
  assign lt   = lt_reg;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// tb_seq_mag_comparator: randomized self-checking bench for seq_mag_comparator
// (WIDTH=16, DIGIT=2). Expected flags come from plain integer comparison and
// expected latency from a digit scan of the raw operands.
module tb_seq_mag_comparator;

  localparam int WIDTH = 16;
  localparam int DIGIT = 2;
  localparam int N     = WIDTH / DIGIT;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;

  int assert_count = 0;
  int fail_count   = 0;

  seq_mag_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .signed_mode(signed_mode), .busy(busy), .done(done),
    .gt(gt), .eq(eq), .lt(lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ordering: {gt,eq,lt} from integer comparison.
  function automatic logic [2:0] ref_flags(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic sm);
    int xi, yi;
    if (sm) begin
      xi = int'($signed(x));
      yi = int'($signed(y));
    end else begin
      xi = int'(x);
      yi = int'(y);
    end
    if (xi > yi) return 3'b100;
    if (xi == yi) return 3'b010;
    return 3'b001;
  endfunction

  // Reference latency: 1-based index of the first differing digit, or N.
  function automatic int ref_latency(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef EARLY_EXIT_EN
    int sh;
    for (int k = 1; k <= N; k++) begin
      sh = WIDTH - k * DIGIT;
      if (((int'(x) >> sh) % (1 << DIGIT)) != ((int'(y) >> sh) % (1 << DIGIT))) return k;
    end
`endif
    return N;
  endfunction

  // Waits for done after an accept edge; cyc = edges counted from the accept.
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done && cyc < 40);
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic accept(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic sm);
    @(negedge clk);
    a = x; b = y; signed_mode = sm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic do_cmp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic sm);
    int cyc;
    accept(x, y, sm);
    wait_done(cyc);
    check("latency", 32'(cyc), 32'(ref_latency(x, y)));
    check("flags", {29'd0, gt, eq, lt}, {29'd0, ref_flags(x, y, sm)});
    check("busy_in_done", 32'(busy), 32'd0);
    $display("cmp a=%04h b=%04h sm=%0d -> gt=%0d eq=%0d lt=%0d lat=%0d", x, y, sm, gt, eq, lt, cyc);
  endtask

  initial begin
    int cyc;
    logic [WIDTH-1:0] ca, cb, na, nb;
    logic csm, nsm;
    logic [2:0] held;
    logic saw_done;

    // Reset held with start asserted: reset must win.
    rst_n = 1'b0; start = 1'b1; a = 16'h1111; b = 16'h2222; signed_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_flags", {29'd0, gt, eq, lt}, 32'd0);
    @(negedge clk);
    start = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Directed cases.
    do_cmp(16'h1234, 16'h1234, 1'b0);
    do_cmp(16'h8000, 16'h7FFF, 1'b0);
    do_cmp(16'h8000, 16'h7FFF, 1'b1);
    do_cmp(16'h0001, 16'h0002, 1'b0);
    do_cmp(16'hFFFF, 16'h0000, 1'b1);

    // Flags hold in IDLE with no new request.
    held = {gt, eq, lt};
    repeat (3) @(negedge clk);
    check("flags_hold", {29'd0, gt, eq, lt}, {29'd0, held});
    check("done_single_cycle", 32'(done), 32'd0);

    // Start pulsed while busy is ignored.
    accept(16'hFFFF, 16'h0000, 1'b0);
    @(negedge clk);
    a = 16'h0000; b = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    if (!done) begin
      int more;
      wait_done(more);
      cyc += more;
    end
    check("busy_start_latency", 32'(cyc), 32'(ref_latency(16'hFFFF, 16'h0000)));
    check("busy_start_flags", {29'd0, gt, eq, lt}, 32'b100);
    repeat (2) @(negedge clk);
    check("busy_start_no_queue", 32'(busy), 32'd0);

    // Reset during the second RUN cycle aborts without a done pulse.
    accept(16'h0001, 16'h0000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_flags", {29'd0, gt, eq, lt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    $display("abort test done");

    // Randomized compares, biased towards equal and near-equal operands.
    for (int i = 0; i < 40; i++) begin
      na  = WIDTH'($urandom);
      nsm = 1'($urandom);
      case ($urandom_range(0, 3))
        0: nb = na;
        1: nb = na ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
        default: nb = WIDTH'($urandom);
      endcase
      do_cmp(na, nb, nsm);
    end

    // Back-to-back: start held, each done cycle accepts the next request.
    @(negedge clk);
    ca = WIDTH'($urandom); cb = ca ^ 16'h0003; csm = 1'b1;
    a = ca; b = cb; signed_mode = csm; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      na = WIDTH'($urandom); nb = (i % 2 == 0) ? na : WIDTH'($urandom); nsm = 1'($urandom);
      a = na; b = nb; signed_mode = nsm;
      wait_done(cyc);
      check("b2b_latency", 32'(cyc), 32'(ref_latency(ca, cb)));
      check("b2b_flags", {29'd0, gt, eq, lt}, {29'd0, ref_flags(ca, cb, csm)});
      $display("b2b a=%04h b=%04h sm=%0d -> gt=%0d eq=%0d lt=%0d lat=%0d", ca, cb, csm, gt, eq, lt, cyc);
      @(posedge clk); #1;
      check("b2b_clear", {29'd0, gt, eq, lt}, 32'd0);
      check("b2b_reaccept", 32'(busy), 32'd1);
      ca = na; cb = nb; csm = nsm;
    end
    start = 1'b0;
    wait_done(cyc);
    check("b2b_last_flags", {29'd0, gt, eq, lt}, {29'd0, ref_flags(ca, cb, csm)});

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
